// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the core-to-memory arbiter and its helpers.
// Latency: n/a; backpressure: n/a.
package cpu_mem_arbiter_pkg;

    localparam logic [6:0] S_IDLE    = 7'b000_0001;
    localparam logic [6:0] S_I_ISSUE = 7'b000_0010;
    localparam logic [6:0] S_I_WAIT  = 7'b000_0100;
    localparam logic [6:0] S_I_RESP  = 7'b000_1000;
    localparam logic [6:0] S_D_ISSUE = 7'b001_0000;
    localparam logic [6:0] S_D_WAIT  = 7'b010_0000;
    localparam logic [6:0] S_D_RESP  = 7'b100_0000;

    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam int          DEFAULT_TIMEOUT = 1024;
    localparam int          DEFAULT_CNT_W   = 11;

    typedef enum logic [6:0] {
        IDLE    = S_IDLE,
        I_ISSUE = S_I_ISSUE,
        I_WAIT  = S_I_WAIT,
        I_RESP  = S_I_RESP,
        D_ISSUE = S_D_ISSUE,
        D_WAIT  = S_D_WAIT,
        D_RESP  = S_D_RESP
    } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Response-timeout counter: clr zeroes it, en counts, expire flags TIMEOUT-1.
// Latency: expire is combinational from the count; backpressure: none, holds at the limit.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Serialises the core's fetch and load/store channels onto one req/gnt+rvalid memory bus.
// Latency: fetch accept->Inst_Valid 3 cycles minimum; store accept->IDLE 2 cycles minimum.
// Backpressure: one transaction in flight; requests wait in IDLE, responses hold until acked.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    state_t state_q, state_d;
    logic   data_req;
    logic   in_issue;
    logic   in_wait;
    logic   expire;

    assign data_req = MemRead | MemWrite;
    assign in_issue = (state_q == I_ISSUE) || (state_q == D_ISSUE);
    assign in_wait  = (state_q == I_WAIT)  || (state_q == D_WAIT);

    // Acks are gated by rst so a request seen during reset is never claimed as taken.
    assign Mem_Req_Ack     = !rst && (state_q == IDLE) && data_req;
    assign Inst_Req_Ack    = !rst && (state_q == IDLE) && Inst_Req_Valid && !data_req;
    assign mem_req         = in_issue;
    assign Inst_Valid      = (state_q == I_RESP);
    assign Read_data_Valid = (state_q == D_RESP);

    mem_timeout_cnt #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (in_issue && mem_gnt),
        .en    (in_wait),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_req) begin
                    state_d = D_ISSUE;
                end else if (Inst_Req_Valid) begin
                    state_d = I_ISSUE;
                end
            end
            I_ISSUE: if (mem_gnt) state_d = mem_we ? IDLE : I_WAIT;
            D_ISSUE: if (mem_gnt) state_d = mem_we ? IDLE : D_WAIT;
            I_WAIT:  if (mem_rvalid || expire) state_d = I_RESP;
            D_WAIT:  if (mem_rvalid || expire) state_d = D_RESP;
            I_RESP:  if (Inst_Ack) state_d = IDLE;
            D_RESP:  if (Read_data_Ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            mem_we      <= 1'b0;
            Instruction <= '0;
            Read_data   <= '0;
            bus_err     <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (data_req) begin
                    // A simultaneous read+write request resolves to the write.
                    mem_addr  <= Address & ADDR_ALIGN_MASK;
                    mem_wdata <= Write_data;
                    mem_wstrb <= MemWrite ? Write_strb : 4'b0000;
                    mem_we    <= MemWrite;
                end else if (Inst_Req_Valid) begin
                    mem_addr  <= PC & ADDR_ALIGN_MASK;
                    mem_wstrb <= 4'b0000;
                    mem_we    <= 1'b0;
                end
            end
            // rvalid on the expiry cycle still delivers data and leaves bus_err alone.
            if (state_q == I_WAIT) begin
                if (mem_rvalid) begin
                    Instruction <= mem_rdata;
                end else if (expire) begin
                    Instruction <= '0;
                    bus_err     <= 1'b1;
                end
            end
            if (state_q == D_WAIT) begin
                if (mem_rvalid) begin
                    Read_data <= mem_rdata;
                end else if (expire) begin
                    Read_data <= '0;
                    bus_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomised transaction-level bench for cpu_mem_arbiter with a small timeout.
module tb_cpu_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ack(Inst_Req_Ack),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ack(Inst_Ack),
        .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data),
        .Write_strb(Write_strb), .MemRead(MemRead), .Mem_Req_Ack(Mem_Req_Ack),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    // kind: 0 fetch, 1 load, 2 store. Inputs change just after a falling edge, outputs are
    // sampled 1ns later. Returns 1ns into the first IDLE cycle after the transaction.
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int gnt_dly, input int rv_dly,
                          input int ack_dly, input bit inst_hold, input bit both_rw,
                          input string tag);
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        logic        exp_we;
        logic        timed_out;
        int          n;
        exp_addr = {addr[31:2], 2'b00};
        exp_we   = (kind == 2);
        exp_strb = exp_we ? strb : 4'h0;

        if (kind == 0) begin
            PC = addr;
            Inst_Req_Valid = 1'b1;
        end else begin
            Address    = addr;
            Write_data = data;
            Write_strb = strb;
            MemWrite   = exp_we;
            MemRead    = (kind == 1) || both_rw;
            if (inst_hold) begin
                Inst_Req_Valid = 1'b1;
                PC = $urandom;
            end
        end
        #1;
        checks++;
        if ({Inst_Req_Ack, Mem_Req_Ack, mem_req} !== {kind == 0, kind != 0, 1'b0}) begin
            errors++;
            $display("FAIL %s accept: inst_ack/mem_ack/req got %b%b%b want %b%b0", tag,
                     Inst_Req_Ack, Mem_Req_Ack, mem_req, kind == 0, kind != 0);
        end
        @(negedge clk);
        MemRead = 1'b0;
        MemWrite = 1'b0;
        if (!inst_hold) Inst_Req_Valid = 1'b0;
        if (!inst_hold) PC = $urandom;
        Address    = $urandom;
        Write_data = $urandom;
        Write_strb = 4'($urandom);

        for (int g = 0; g <= gnt_dly; g++) begin
            mem_gnt    = (g == gnt_dly);
            mem_rvalid = ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            #1;
            checks++;
            if ({mem_req, mem_we, mem_wstrb, mem_addr} !== {1'b1, exp_we, exp_strb, exp_addr}) begin
                errors++;
                $display("FAIL %s issue: req/we/strb/addr got %b %b %h %h want 1 %b %h %h", tag,
                         mem_req, mem_we, mem_wstrb, mem_addr, exp_we, exp_strb, exp_addr);
            end
            if (exp_we) begin
                checks++;
                if (mem_wdata !== data) begin
                    errors++;
                    $display("FAIL %s wdata: got %h want %h", tag, mem_wdata, data);
                end
            end
            checks++;
            if ({Inst_Valid, Read_data_Valid, Inst_Req_Ack, Mem_Req_Ack} !== 4'b0000) begin
                errors++;
                $display("FAIL %s issue_quiet: valids/acks got %b%b%b%b want 0000", tag,
                         Inst_Valid, Read_data_Valid, Inst_Req_Ack, Mem_Req_Ack);
            end
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;

        if (!exp_we) begin
            timed_out = (rv_dly > TO);
            n = timed_out ? TO : rv_dly;
            for (int w = 1; w <= n; w++) begin
                mem_rvalid    = (w == rv_dly);
                mem_rdata     = (w == rv_dly) ? data : $urandom;
                mem_gnt       = ($urandom_range(0, 1) == 1);
                Inst_Ack      = ($urandom_range(0, 1) == 1);
                Read_data_Ack = ($urandom_range(0, 1) == 1);
                #1;
                checks++;
                if ({mem_req, Inst_Valid, Read_data_Valid} !== 3'b000) begin
                    errors++;
                    $display("FAIL %s wait%0d: req/ivld/dvld got %b%b%b want 000", tag, w,
                             mem_req, Inst_Valid, Read_data_Valid);
                end
                @(negedge clk);
            end
            exp_data = timed_out ? 32'h0 : data;
            if (timed_out) exp_err = 1'b1;
            for (int h = 0; h <= ack_dly; h++) begin
                mem_rvalid = ($urandom_range(0, 1) == 1);
                mem_rdata  = $urandom;
                mem_gnt    = ($urandom_range(0, 1) == 1);
                if (kind == 0) begin
                    Inst_Ack      = (h == ack_dly);
                    Read_data_Ack = ($urandom_range(0, 1) == 1);
                end else begin
                    Read_data_Ack = (h == ack_dly);
                    Inst_Ack      = ($urandom_range(0, 1) == 1);
                end
                #1;
                checks++;
                if ({Inst_Valid, Read_data_Valid, mem_req} !== {kind == 0, kind != 0, 1'b0}) begin
                    errors++;
                    $display("FAIL %s resp_valid: ivld/dvld/req got %b%b%b want %b%b0", tag,
                             Inst_Valid, Read_data_Valid, mem_req, kind == 0, kind != 0);
                end
                checks++;
                if (((kind == 0) ? Instruction : Read_data) !== exp_data) begin
                    errors++;
                    $display("FAIL %s resp_data: got %h want %h", tag,
                             (kind == 0) ? Instruction : Read_data, exp_data);
                end
                checks++;
                if (bus_err !== exp_err) begin
                    errors++;
                    $display("FAIL %s bus_err: got %b want %b", tag, bus_err, exp_err);
                end
                if (inst_hold) begin
                    checks++;
                    if (Inst_Req_Ack !== 1'b0) begin
                        errors++;
                        $display("FAIL %s held_fetch: Inst_Req_Ack got %b want 0", tag, Inst_Req_Ack);
                    end
                end
                @(negedge clk);
            end
        end
        mem_rvalid = 1'b0;
        mem_gnt = 1'b0;
        Inst_Ack = 1'b0;
        Read_data_Ack = 1'b0;
        #1;
        checks++;
        if ({mem_req, Inst_Valid, Read_data_Valid} !== 3'b000) begin
            errors++;
            $display("FAIL %s idle: req/ivld/dvld got %b%b%b want 000", tag,
                     mem_req, Inst_Valid, Read_data_Valid);
        end
        if (inst_hold) begin
            checks++;
            if (Inst_Req_Ack !== 1'b1) begin
                errors++;
                $display("FAIL %s fetch_after: Inst_Req_Ack got %b want 1", tag, Inst_Req_Ack);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data, Read_data_Valid,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs not all zero, addr %h instr %h err %b",
                     mem_addr, Instruction, bus_err);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data, Read_data_Valid,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs not all zero, req %b err %b", mem_req, bus_err);
        end
    endtask

    task automatic test_fetch();
        do_txn(0, 32'h0000_0104, 32'h0010_0093, 4'h0, 0, 1, 0, 1'b0, 1'b0, "fetch");
    endtask

    task automatic test_store_then_load();
        do_txn(2, 32'h0000_0200, 32'hABAB_ABAB, 4'b0100, 3, 0, 0, 1'b0, 1'b0, "store");
        do_txn(1, 32'h0000_0300, 32'hDEAD_BEEF, 4'hF, 0, 5, 2, 1'b0, 1'b0, "load_slow");
    endtask

    task automatic test_priority();
        do_txn(1, 32'h0000_0500, 32'h1357_9BDF, 4'h0, 1, 2, 1, 1'b1, 1'b0, "prio_load");
        do_txn(0, 32'h0000_0600, 32'h0000_0013, 4'h0, 0, 1, 0, 1'b0, 1'b0, "prio_fetch");
    endtask

    task automatic test_timeout();
        do_txn(0, 32'h0000_0700, 32'h1234_5678, 4'h0, 0, TO, 0, 1'b0, 1'b0, "rvalid_at_limit");
        do_txn(0, 32'h0000_0704, 32'hFFFF_FFFF, 4'h0, 0, TO + 1, 1, 1'b0, 1'b0, "timeout");
        do_txn(1, 32'h0000_0800, 32'h0BAD_F00D, 4'h0, 0, 1, 0, 1'b0, 1'b0, "sticky_err");
    endtask

    task automatic test_random(input int count);
        for (int i = 0; i < count; i++) begin
            int rv;
            rv = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                             : int'($urandom_range(1, 4));
            do_txn(int'($urandom_range(0, 2)), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(0, 3)), rv, int'($urandom_range(0, 2)), 1'b0,
                   ($urandom_range(0, 1) == 1), "rand");
        end
    endtask

    task automatic test_reset_midop();
        PC = 32'h0000_0404;
        Inst_Req_Valid = 1'b1;
        #1;
        checks++;
        if (Inst_Req_Ack !== 1'b1) begin
            errors++;
            $display("FAIL midop_accept: Inst_Req_Ack got %b want 1", Inst_Req_Ack);
        end
        @(negedge clk);
        Inst_Req_Valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        checks++;
        if ({mem_req, Inst_Valid, mem_addr} !== {2'b00, 32'h0000_0404}) begin
            errors++;
            $display("FAIL midop_wait: req/ivld/addr got %b%b %h want 00 00000404",
                     mem_req, Inst_Valid, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_gnt = 1'b1;
        mem_rdata = $urandom;
        #1;
        checks++;
        if ({Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data, Read_data_Valid,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err} !== '0) begin
            errors++;
            $display("FAIL midop_reset: outputs not zero, addr %h err %b ivld %b",
                     mem_addr, bus_err, Inst_Valid);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_gnt = 1'b0;
        #1;
        checks++;
        if ({Inst_Valid, Instruction, mem_req, bus_err} !== '0) begin
            errors++;
            $display("FAIL midop_stray: ivld/instr/req/err got %b %h %b %b want 0 0 0 0",
                     Inst_Valid, Instruction, mem_req, bus_err);
        end
        exp_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        PC = '0; Inst_Req_Valid = 1'b0; Inst_Ack = 1'b0;
        Address = '0; MemWrite = 1'b0; Write_data = '0; Write_strb = '0; MemRead = 1'b0;
        Read_data_Ack = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_fetch();
        test_store_then_load();
        test_priority();
        test_timeout();
        test_random(30);
        test_reset_midop();
        test_random(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
